audio_dac_i2s_tx: RTL and testbench

- Sits downstream of the jingle sample sender. Buffers its 16-bit mono samples in an internal FIFO and reports almost-full back to the sender.
- Serializes the samples to the audio codec DAC as I2S frames. Each sample is sent on both the left and right slot.
- Generates BCLK and DACLRCK itself as master, using only clk_i.

---
 rtl/audio_dac_i2s_tx_if.sv | 31 +++
 rtl/audio_dac_i2s_tx.sv | 158 +++++++++++++++
 tb/tb_audio_dac_i2s_tx.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_dac_i2s_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_dac_i2s_tx_if
// Description : Sample-side bus between the jingle sender and the I2S DAC
//               transmitter (write strobe, flush, FIFO status).
// Revision    : 1.0 - initial release
// ============================================================================
interface audio_dac_i2s_tx_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 64
);
    logic [SAMPLE_WIDTH-1:0]       samp_data_i;
    logic                          samp_wr_req_i;
    logic                          clear_i;
    logic                          almfull_o;
    logic                          empty_o;
    logic [$clog2(FIFO_DEPTH):0]   usedw_o;
    logic                          overflow_o;
    logic                          underrun_o;

    modport master (
        output samp_data_i, samp_wr_req_i, clear_i,
        input  almfull_o, empty_o, usedw_o, overflow_o, underrun_o
    );

    modport slave (
        input  samp_data_i, samp_wr_req_i, clear_i,
        output almfull_o, empty_o, usedw_o, overflow_o, underrun_o
    );
endinterface
`default_nettype wire

// File: rtl/audio_dac_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : audio_dac_i2s_tx
// Description : Sample FIFO plus I2S master serializer (mono sample sent on
//               both slots). Define DAC_LEFT_JUSTIFIED_EN for left-justified.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_dac_i2s_tx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 64,
    parameter int ALMFULL_LVL  = 56,
    parameter int BCLK_DIV     = 4,
    parameter int SLOT_BITS    = 16
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    audio_dac_i2s_tx_if.slave     bus,
    output logic                  aud_bclk_o,
    output logic                  aud_daclrck_o,
    output logic                  aud_dacdat_o
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_UW = c_AW + 1;
    localparam int c_CW = $clog2(2 * SLOT_BITS);
    localparam int c_DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(2 * SLOT_BITS - 1);
    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(BCLK_DIV - 1);

    logic [SAMPLE_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]         r_wr_ptr;
    logic [c_AW-1:0]         r_rd_ptr;
    logic [c_UW-1:0]         r_usedw;
    logic                    r_almfull;
    logic                    r_overflow;
    logic                    r_underrun;

    logic [c_DW-1:0]         r_div;
    logic                    r_bclk;
    logic                    r_lrck;
    logic                    r_dacdat;
    logic [c_CW-1:0]         r_cnt;
    logic [SAMPLE_WIDTH-1:0] r_sample;
    logic [SLOT_BITS-1:0]    r_shift;

    logic                    w_empty;
    logic                    w_full;
    logic                    w_wr;
    logic                    w_pop;
    logic                    w_div_tc;
    logic                    w_fall;
    logic [c_CW-1:0]         w_cnt_next;
    logic                    w_load;
    logic                    w_slot_start;
    logic [SAMPLE_WIDTH-1:0] w_cur_sample;
    logic [SLOT_BITS-1:0]    w_cur_pad;

    assign w_empty      = (r_usedw == '0);
    assign w_full       = (r_usedw == c_UW'(FIFO_DEPTH));
    assign w_div_tc     = (r_div == c_DIV_LAST);
    assign w_fall       = w_div_tc && r_bclk;
    assign w_cnt_next   = (r_cnt == c_CNT_LAST) ? '0 : r_cnt + c_CW'(1);
    assign w_load       = w_fall && (w_cnt_next == '0);
    assign w_slot_start = (w_cnt_next == '0) || (w_cnt_next == c_CW'(SLOT_BITS));
    // Full is judged on the pre-pop count, so a pop never rescues a write.
    assign w_wr         = bus.samp_wr_req_i && !w_full && !bus.clear_i;
    assign w_pop        = w_load && !w_empty && !bus.clear_i;
    assign w_cur_sample = w_load ? (w_pop ? r_mem[r_rd_ptr] : '0) : r_sample;
    assign w_cur_pad    = SLOT_BITS'(w_cur_sample) << (SLOT_BITS - SAMPLE_WIDTH);

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.samp_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_usedw    <= '0;
            r_almfull  <= 1'b0;
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_overflow <= bus.samp_wr_req_i && w_full && !bus.clear_i;
            r_underrun <= w_load && !w_pop;
            r_almfull  <= (r_usedw >= c_UW'(ALMFULL_LVL));
            if (bus.clear_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_usedw  <= '0;
            end else begin
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + c_AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_AW'(1);
                end
                if (w_wr && !w_pop) begin
                    r_usedw <= r_usedw + c_UW'(1);
                end else if (!w_wr && w_pop) begin
                    r_usedw <= r_usedw - c_UW'(1);
                end
            end
        end
    end

    // Serializer state moves only on the clk cycle that drops BCLK.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div    <= '0;
            r_bclk   <= 1'b0;
            r_lrck   <= 1'b1;
            r_dacdat <= 1'b0;
            r_cnt    <= c_CNT_LAST;
            r_sample <= '0;
            r_shift  <= '0;
        end else begin
            if (w_div_tc) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_div  <= r_div + c_DW'(1);
            end
            if (w_fall) begin
                r_cnt  <= w_cnt_next;
                r_lrck <= (w_cnt_next >= c_CW'(SLOT_BITS));
                if (w_load) begin
                    r_sample <= w_cur_sample;
                end
`ifdef DAC_LEFT_JUSTIFIED_EN
                if (w_slot_start) begin
                    r_dacdat <= w_cur_pad[SLOT_BITS-1];
                    r_shift  <= w_cur_pad << 1;
                end else begin
                    r_dacdat <= r_shift[SLOT_BITS-1];
                    r_shift  <= r_shift << 1;
                end
`else
                // Slot start emits what is left in the shifter: the previous
                // slot's LSB when slots are exactly sample-wide, else padding.
                r_dacdat <= r_shift[SLOT_BITS-1];
                r_shift  <= w_slot_start ? w_cur_pad : (r_shift << 1);
`endif
            end
        end
    end

    assign bus.almfull_o  = r_almfull;
    assign bus.empty_o    = w_empty;
    assign bus.usedw_o    = r_usedw;
    assign bus.overflow_o = r_overflow;
    assign bus.underrun_o = r_underrun;
    assign aud_bclk_o     = r_bclk;
    assign aud_daclrck_o  = r_lrck;
    assign aud_dacdat_o   = r_dacdat;
endmodule
`default_nettype wire

// File: tb/tb_audio_dac_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_dac_i2s_tx
// Description : Self-checking bench for audio_dac_i2s_tx against a queue and
//               timing-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_dac_i2s_tx;
    localparam int SW    = 16;
    localparam int DEPTH = 64;
    localparam int ALM   = 56;
    localparam int BDIV  = 4;
    localparam int SLOT  = 16;
    localparam int FRAME = 2 * SLOT * 2 * BDIV;
    localparam int LOADP = 2 * BDIV;
`ifdef DAC_LEFT_JUSTIFIED_EN
    localparam logic [SW-1:0] PAT = 16'h8001;
`else
    localparam logic [SW-1:0] PAT = 16'hA5A5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bclk, lrck, dac;

    audio_dac_i2s_tx_if #(.SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH)) bus ();

    audio_dac_i2s_tx #(
        .SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH), .ALMFULL_LVL(ALM),
        .BCLK_DIV(BDIV), .SLOT_BITS(SLOT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .aud_bclk_o(bclk), .aud_daclrck_o(lrck), .aud_dacdat_o(dac)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: time since reset release decides BCLK/slot position,
    // a queue stands in for the FIFO.
    int t = 0;
    logic [SW-1:0] q[$];
    logic [SW-1:0] cur_s, prev_s, src_s;
    logic e_bclk, e_lrck, e_dac, e_under, e_over, e_alm;
    int mn, mm, mc, mk;
    logic mload;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t = 0; q.delete(); cur_s = '0; prev_s = '0;
            e_bclk = 0; e_lrck = 1; e_dac = 0; e_under = 0; e_over = 0; e_alm = 0;
        end else begin
            t = t + 1;
            mn = q.size();
            mload = 0;
            if (t % (2 * BDIV) == 0) begin
                mm = t / (2 * BDIV);
                mc = (mm - 1) % (2 * SLOT);
                mk = mc % SLOT;
                e_lrck = (mc >= SLOT);
                if (mc == 0) begin
                    mload  = 1;
                    prev_s = cur_s;
                    cur_s  = (!bus.clear_i && mn > 0) ? q[0] : '0;
                end
`ifdef DAC_LEFT_JUSTIFIED_EN
                e_dac = (mk < SW) ? cur_s[SW-1-mk] : 1'b0;
`else
                src_s = (mc == 0) ? prev_s : cur_s;
                if (mk == 0)        e_dac = (SLOT == SW) ? src_s[0] : 1'b0;
                else if (mk <= SW)  e_dac = cur_s[SW-mk];
                else                e_dac = 1'b0;
`endif
            end
            e_bclk  = ((t / BDIV) % 2) == 1;
            e_under = mload && (bus.clear_i || mn == 0);
            e_over  = bus.samp_wr_req_i && (mn == DEPTH) && !bus.clear_i;
            e_alm   = (mn >= ALM);
            if (bus.clear_i) begin
                q.delete();
            end else begin
                if (mload && mn > 0) void'(q.pop_front());
                if (bus.samp_wr_req_i && mn < DEPTH) q.push_back(bus.samp_data_i);
            end
        end
    end

    task automatic wait_phase(input int p);
        do @(negedge clk); while (t % FRAME != p);
    endtask

    task automatic test_reset();
        bus.samp_wr_req_i = 1'b0;
        bus.clear_i       = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.usedw_o !== '0)    $display("FAIL rst_usedw got %0d exp 0", bus.usedw_o); else n_pass++;
        n_checks++; if (bus.empty_o !== 1'b1)  $display("FAIL rst_empty got %b exp 1", bus.empty_o); else n_pass++;
        n_checks++; if (bus.almfull_o !== 1'b0) $display("FAIL rst_almfull got %b exp 0", bus.almfull_o); else n_pass++;
        n_checks++; if (bus.overflow_o !== 1'b0) $display("FAIL rst_overflow got %b exp 0", bus.overflow_o); else n_pass++;
        n_checks++; if (bus.underrun_o !== 1'b0) $display("FAIL rst_underrun got %b exp 0", bus.underrun_o); else n_pass++;
        n_checks++; if (bclk !== 1'b0) $display("FAIL rst_bclk got %b exp 0", bclk); else n_pass++;
        n_checks++; if (lrck !== 1'b1) $display("FAIL rst_lrck got %b exp 1", lrck); else n_pass++;
        n_checks++; if (dac !== 1'b0)  $display("FAIL rst_dacdat got %b exp 0", dac); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle(input int n);
        int pulses = 0;
        int exp_p  = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (t % FRAME == LOADP) exp_p++;
            if (bus.underrun_o === 1'b1) pulses++;
            n_checks++; if (bclk !== e_bclk) $display("FAIL idle_bclk t=%0d got %b exp %b", t, bclk, e_bclk); else n_pass++;
            n_checks++; if (lrck !== e_lrck) $display("FAIL idle_lrck t=%0d got %b exp %b", t, lrck, e_lrck); else n_pass++;
            n_checks++; if (dac !== 1'b0) $display("FAIL idle_dacdat t=%0d got %b exp 0", t, dac); else n_pass++;
            n_checks++; if (bus.underrun_o !== e_under) $display("FAIL idle_underrun t=%0d got %b exp %b", t, bus.underrun_o, e_under); else n_pass++;
            n_checks++; if (bus.empty_o !== 1'b1) $display("FAIL idle_empty t=%0d got %b exp 1", t, bus.empty_o); else n_pass++;
        end
        n_checks++; if (pulses !== exp_p) $display("FAIL idle_underrun_count got %0d exp %0d", pulses, exp_p); else n_pass++;
    endtask

    task automatic test_single();
        logic [2*SW-1:0] cap;
        wait_phase(200);
        bus.samp_data_i   = PAT;
        bus.samp_wr_req_i = 1'b1;
        @(negedge clk);
        bus.samp_wr_req_i = 1'b0;
        n_checks++; if (bus.usedw_o !== 1) $display("FAIL single_usedw_pre got %0d exp 1", bus.usedw_o); else n_pass++;
        wait_phase(LOADP);
        n_checks++; if (bus.usedw_o !== 0) $display("FAIL single_usedw_post got %0d exp 0", bus.usedw_o); else n_pass++;
        n_checks++; if (bus.underrun_o !== 1'b0) $display("FAIL single_underrun got %b exp 0", bus.underrun_o); else n_pass++;
`ifdef DAC_LEFT_JUSTIFIED_EN
        cap[2*SW-1] = dac;
        for (int j = 1; j < 2 * SW; j++) begin
            repeat (2 * BDIV) @(negedge clk);
            cap[2*SW-1-j] = dac;
        end
`else
        for (int j = 0; j < 2 * SW; j++) begin
            repeat (2 * BDIV) @(negedge clk);
            cap[2*SW-1-j] = dac;
        end
`endif
        n_checks++; if (cap !== {PAT, PAT}) $display("FAIL single_frame_bits got %h exp %h", cap, {PAT, PAT}); else n_pass++;
    endtask

    task automatic test_fill_overflow();
        wait_phase(LOADP);
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            bus.samp_data_i   = SW'($urandom);
            bus.samp_wr_req_i = 1'b1;
            @(negedge clk);
            n_checks++; if (bus.usedw_o !== q.size()) $display("FAIL fill_usedw i=%0d got %0d exp %0d", i, bus.usedw_o, q.size()); else n_pass++;
            n_checks++; if (bus.almfull_o !== e_alm) $display("FAIL fill_almfull i=%0d got %b exp %b", i, bus.almfull_o, e_alm); else n_pass++;
            n_checks++; if (bus.overflow_o !== e_over) $display("FAIL fill_overflow i=%0d got %b exp %b", i, bus.overflow_o, e_over); else n_pass++;
            if (i == ALM - 1) begin
                n_checks++; if (bus.almfull_o !== 1'b0) $display("FAIL almfull_lag got %b exp 0", bus.almfull_o); else n_pass++;
            end
            if (i == ALM) begin
                n_checks++; if (bus.almfull_o !== 1'b1) $display("FAIL almfull_set got %b exp 1", bus.almfull_o); else n_pass++;
            end
        end
        n_checks++; if (bus.usedw_o !== DEPTH) $display("FAIL full_usedw got %0d exp %0d", bus.usedw_o, DEPTH); else n_pass++;
        n_checks++; if (bus.overflow_o !== 1'b1) $display("FAIL full_overflow got %b exp 1", bus.overflow_o); else n_pass++;
        for (int i = 0; i < FRAME && (t % FRAME != LOADP); i++) begin
            bus.samp_data_i = SW'($urandom);
            @(negedge clk);
            n_checks++; if (bus.overflow_o !== e_over) $display("FAIL hold_overflow t=%0d got %b exp %b", t, bus.overflow_o, e_over); else n_pass++;
        end
        bus.samp_wr_req_i = 1'b0;
        n_checks++; if (bus.overflow_o !== 1'b1) $display("FAIL load_overflow got %b exp 1", bus.overflow_o); else n_pass++;
        n_checks++; if (bus.usedw_o !== DEPTH - 1) $display("FAIL load_usedw got %0d exp %0d", bus.usedw_o, DEPTH - 1); else n_pass++;
    endtask

    task automatic test_clear();
        wait_phase(16);
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.samp_data_i   = SW'($urandom);
            bus.samp_wr_req_i = 1'b1;
            @(negedge clk);
        end
        bus.samp_wr_req_i = 1'b0;
        n_checks++; if (bus.usedw_o !== 10) $display("FAIL clear_pre_usedw got %0d exp 10", bus.usedw_o); else n_pass++;
        wait_phase(100);
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        n_checks++; if (bus.usedw_o !== 0) $display("FAIL clear_usedw got %0d exp 0", bus.usedw_o); else n_pass++;
        n_checks++; if (bus.empty_o !== 1'b1) $display("FAIL clear_empty got %b exp 1", bus.empty_o); else n_pass++;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            n_checks++; if (dac !== e_dac) $display("FAIL clear_dacdat t=%0d got %b exp %b", t, dac, e_dac); else n_pass++;
            n_checks++; if (lrck !== e_lrck) $display("FAIL clear_lrck t=%0d got %b exp %b", t, lrck, e_lrck); else n_pass++;
            n_checks++; if (bus.underrun_o !== e_under) $display("FAIL clear_underrun t=%0d got %b exp %b", t, bus.underrun_o, e_under); else n_pass++;
            if (t % FRAME == LOADP) begin
                n_checks++; if (bus.underrun_o !== 1'b1) $display("FAIL clear_next_underrun got %b exp 1", bus.underrun_o); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back(input int n);
        for (int i = 0; i < n; i++) begin
            bus.samp_data_i   = SW'($urandom);
            bus.samp_wr_req_i = ($urandom_range(0, 199) < 2);
            bus.clear_i       = ($urandom_range(0, 1499) == 0);
            @(negedge clk);
            n_checks++; if (bclk !== e_bclk) $display("FAIL b2b_bclk t=%0d got %b exp %b", t, bclk, e_bclk); else n_pass++;
            n_checks++; if (lrck !== e_lrck) $display("FAIL b2b_lrck t=%0d got %b exp %b", t, lrck, e_lrck); else n_pass++;
            n_checks++; if (dac !== e_dac) $display("FAIL b2b_dacdat t=%0d got %b exp %b", t, dac, e_dac); else n_pass++;
            n_checks++; if (bus.usedw_o !== q.size()) $display("FAIL b2b_usedw t=%0d got %0d exp %0d", t, bus.usedw_o, q.size()); else n_pass++;
            n_checks++; if (bus.empty_o !== (q.size() == 0)) $display("FAIL b2b_empty t=%0d got %b exp %b", t, bus.empty_o, q.size() == 0); else n_pass++;
            n_checks++; if (bus.almfull_o !== e_alm) $display("FAIL b2b_almfull t=%0d got %b exp %b", t, bus.almfull_o, e_alm); else n_pass++;
            n_checks++; if (bus.overflow_o !== e_over) $display("FAIL b2b_overflow t=%0d got %b exp %b", t, bus.overflow_o, e_over); else n_pass++;
            n_checks++; if (bus.underrun_o !== e_under) $display("FAIL b2b_underrun t=%0d got %b exp %b", t, bus.underrun_o, e_under); else n_pass++;
        end
        bus.samp_wr_req_i = 1'b0;
        bus.clear_i       = 1'b0;
    endtask

    initial begin
        bus.samp_data_i   = '0;
        bus.samp_wr_req_i = 1'b0;
        bus.clear_i       = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_idle(600);
        test_single();
        test_fill_overflow();
        test_clear();
        test_back_to_back(4000);
        test_reset();
        test_idle(600);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
